prime_request_gen: RTL and testbench
====================================

# prime_request_gen

Upstream request stage for the 7-bit next-prime finder. It produces a pseudo-random 7-bit candidate from a free-running LFSR and, on a start request, presents the candidate on `Q_in` with a one-cycle `FindPrime` pulse. It then waits a fixed search window and captures the finder's `Q_out` result into `prime_out` with a `done` strobe. It replaces manual entry of candidates with an automated request/result handshake.

## Interface
- `WAIT_CYCLES`, default 3000: search window in cycles after issue. Legal range 1..65535. The default covers the worst-case 7-bit search.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; rising edge sampled in IDLE only.
- `seed_load`  in  1  when 1, load `seed` into the LFSR at this edge.
- `seed`  in  7  LFSR seed value; 7'h00 is mapped to 7'h01.
- `prime_in`  in  7  result from the finder's `Q_out`.
- `Q_in`  out  7  candidate to the finder; held stable from ISSUE until the next request.
- `FindPrime`  out  1  one-cycle load pulse to the finder.
- `prime_out`  out  7  captured prime result.
- `done`  out  1  one-cycle strobe when `prime_out` updates.
- `busy`  out  1  high in ISSUE, WAIT and DONE.

## Operation
- **LFSR**
  - 7-bit Fibonacci LFSR, polynomial x^7+x^6+1: `lfsr <= {lfsr[5:0], lfsr[6]^lfsr[5]}` every cycle, in every state.
  - Period is 127; value 0 is never reached.
  - `seed_load` overrides the shift for that edge; a zero seed loads 7'h01.
- **Start detection**: register `start_d <= start`. The request is `start & ~start_d`.
  - A level held high does not retrigger.
  - Edges seen outside IDLE are dropped and are not queued.
- **FSM states**: IDLE, ISSUE, WAIT, DONE.
  - IDLE: on a request, go to ISSUE. At that edge, `Q_in <= lfsr` (pre-update value) and `FindPrime <= 1`.
  - ISSUE, one cycle: `FindPrime <= 0`, `wcnt <= 0`, go to WAIT.
  - WAIT: if `wcnt == WAIT_CYCLES-1`, then `prime_out <= prime_in`, `done <= 1`, go to DONE. Otherwise `wcnt <= wcnt+1`.
  - DONE, one cycle: `done <= 0`, go to IDLE.
- **Counter**: `wcnt` is a 16-bit unsigned counter. It never wraps, because its terminal value is `WAIT_CYCLES-1`.
- **Simultaneous `seed_load` and request in IDLE**:
  - `Q_in` takes the old LFSR value.
  - The LFSR takes the seed.
- `seed_load` is accepted in any state and never changes `Q_in` mid-request.
- `prime_in` is ignored except at the capture edge.
- **Reset**: asserting `rst` in any state immediately forces every register to its reset value. This aborts a request in flight with no `done` strobe.

## Timing
- **Reset values**:
  - `Q_in = 0`, `FindPrime = 0`, `prime_out = 0`, `done = 0`, `busy = 0`.
  - `lfsr = 7'h01`, `start_d = 0`, `wcnt = 0`, state IDLE.
- The first LFSR shift happens at the first edge after `rst` deasserts.
- Let the request be sampled at edge k:
  - `FindPrime` is high in cycle k..k+1 and `Q_in` is valid from k.
  - The state is WAIT from edge k+1.
  - `done` rises at edge k+1+`WAIT_CYCLES` and falls one cycle later.
  - The next request is accepted at edge k+3+`WAIT_CYCLES` or later.
- `busy` is registered and equals (state != IDLE). It rises at edge k and falls at edge k+2+`WAIT_CYCLES`.
- `Q_in` is stable for at least `WAIT_CYCLES`+1 cycles after the `FindPrime` pulse. This satisfies the finder's requirement that the input is held while it searches.

## Test plan
- **LFSR sequence**: release reset with no stimulus. The LFSR sequence read back via repeated requests, or probed internally, is 01, 02, 04, 08, 10, 20, 41, 03 on successive edges.
- **Seeded request**: pulse `seed_load` with `seed` = 7'h0A, then `start` on the next edge, with `WAIT_CYCLES` = 200 and the real finder attached.
  - `Q_in` = 7'h0A with a one-cycle `FindPrime`.
  - `done` arrives exactly 201 cycles after the request edge, with `prime_out` = 7'd11.
- **Zero seed**: `seed` = 0 with `seed_load`, then a request gives `Q_in` = 7'h01. The finder returns 2, captured in `prime_out`.
- **Held and repeated start**: hold `start` high for 500 cycles with `WAIT_CYCLES` = 10. Exactly one `FindPrime` and one `done` occur. A second rising edge during WAIT produces no extra `FindPrime`.
- **Reset mid-request**: drop `rst` in the middle of WAIT. All outputs are 0 immediately with no clock edge. After release, the FSM is in IDLE, the LFSR restarts from 01, and no `done` is seen.
- **Seed load during WAIT**: pulse `seed_load` mid-WAIT with `seed` = 7'h33.
  - `Q_in` is unchanged.
  - The next request issues the LFSR value that follows 7'h33 after the elapsed shifts.

Source files
------------

// File: rtl/prime_request_gen.sv
// Request stage for the 7-bit next-prime finder: issues an LFSR candidate on a start edge,
// waits a fixed search window, then captures the finder result with a done strobe.
module prime_request_gen #(
   parameter int unsigned WAIT_CYCLES = 3000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       seed_load,
   input  logic [6:0] seed,
   input  logic [6:0] prime_in,
   output logic [6:0] Q_in,
   output logic       FindPrime,
   output logic [6:0] prime_out,
   output logic       done,
   output logic       busy
);

   localparam logic [1:0]  S_IDLE    = 2'd0;
   localparam logic [1:0]  S_ISSUE   = 2'd1;
   localparam logic [1:0]  S_WAIT    = 2'd2;
   localparam logic [1:0]  S_DONE    = 2'd3;
   localparam logic [15:0] WCNT_LAST = 16'(WAIT_CYCLES - 32'd1);

   logic [1:0]  state_q, state_d;
   logic [6:0]  lfsr_q, lfsr_d;
   logic        start_prev_q;
   logic [15:0] wcnt_q, wcnt_d;
   logic [6:0]  q_in_q, q_in_d;
   logic [6:0]  prime_q, prime_d;
   logic        find_q, find_d;
   logic        done_q, done_d;
   logic        busy_q;
   logic        req_s;

   assign req_s = start & ~start_prev_q;

   // LFSR next value: a seed load wins over the shift, and zero is never loaded
   always_comb begin
      lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
      if (seed_load) begin
         if (seed == 7'h00) begin
            lfsr_d = 7'h01;
         end else begin
            lfsr_d = seed;
         end
      end else begin
         lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
      end
   end

   // Request/result sequencing; the candidate is taken from the pre-shift LFSR value
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      q_in_d  = q_in_q;
      prime_d = prime_q;
      find_d  = find_q;
      done_d  = done_q;
      case (state_q)
         S_IDLE: begin
            if (req_s) begin
               q_in_d  = lfsr_q;
               find_d  = 1'b1;
               state_d = S_ISSUE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            find_d  = 1'b0;
            wcnt_d  = 16'd0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (wcnt_q == WCNT_LAST) begin
               prime_d = prime_in;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               wcnt_d  = wcnt_q + 16'd1;
            end
         end
         S_DONE: begin
            done_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            find_d  = 1'b0;
            done_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any request in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         lfsr_q       <= 7'h01;
         start_prev_q <= 1'b0;
         wcnt_q       <= 16'd0;
         q_in_q       <= 7'h00;
         prime_q      <= 7'h00;
         find_q       <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         lfsr_q       <= lfsr_d;
         start_prev_q <= start;
         wcnt_q       <= wcnt_d;
         q_in_q       <= q_in_d;
         prime_q      <= prime_d;
         find_q       <= find_d;
         done_q       <= done_d;
         busy_q       <= (state_d != S_IDLE);
      end
   end

   assign Q_in      = q_in_q;
   assign FindPrime = find_q;
   assign prime_out = prime_q;
   assign done      = done_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_prime_request_gen.sv
// Directed bench for prime_request_gen with a behavioural next-prime finder on prime_in.
module tb_prime_request_gen;

   localparam int W = 200;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       seed_load;
   logic [6:0] seed;
   logic [6:0] prime_in;
   logic [6:0] Q_in;
   logic       FindPrime;
   logic [6:0] prime_out;
   logic       done;
   logic       busy;

   int total_cnt = 0;
   int pass_cnt  = 0;
   int fp_cnt    = 0;
   int done_cnt  = 0;
   int cyc       = 0;

   prime_request_gen #(.WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst), .start(start), .seed_load(seed_load), .seed(seed),
      .prime_in(prime_in), .Q_in(Q_in), .FindPrime(FindPrime), .prime_out(prime_out),
      .done(done), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic bit is_prime(input int c);
      if (c < 2) return 1'b0;
      for (int d = 2; d * d <= c; d++) begin
         if (c % d == 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic logic [6:0] next_prime(input logic [6:0] n);
      for (int c = int'(n) + 1; c < 128; c++) begin
         if (is_prime(c)) return 7'(c);
      end
      return 7'd127;
   endfunction

   function automatic logic [6:0] lfsr_step(input logic [6:0] x);
      return {x[5:0], x[6] ^ x[5]};
   endfunction

   assign prime_in = next_prime(Q_in);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (FindPrime === 1'b1) fp_cnt <= fp_cnt + 1;
      if (done === 1'b1) done_cnt <= done_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 1000) begin
         tick();
         n++;
      end
      check("done_timeout", 32'(done), 32'd1);
   endtask

   initial begin
      logic [6:0] seq [8];
      logic [6:0] q_hold;
      logic [6:0] exp_q;
      int         n;
      int         fp0;
      int         d0;
      int         seed_cyc;

      seq = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41, 7'h03};
      rst = 1'b0; start = 1'b0; seed_load = 1'b0; seed = 7'h00;
      #1;
      check("rst_q_in", 32'(Q_in), 32'd0);
      check("rst_findprime", 32'(FindPrime), 32'd0);
      check("rst_prime_out", 32'(prime_out), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);

      // free-running LFSR sequence after reset release
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      check("lfsr_0", 32'(dut.lfsr_q), 32'(seq[0]));
      for (int i = 1; i < 8; i++) begin
         tick();
         check($sformatf("lfsr_%0d", i), 32'(dut.lfsr_q), 32'(seq[i]));
      end

      // seeded request, seed 0x0A
      seed = 7'h0A; seed_load = 1'b1;
      tick();
      seed_load = 1'b0; start = 1'b1;
      tick();
      check("seed_q_in", 32'(Q_in), 32'h0A);
      check("seed_findprime_hi", 32'(FindPrime), 32'd1);
      check("seed_busy", 32'(busy), 32'd1);
      check("seed_done_lo", 32'(done), 32'd0);
      tick();
      check("seed_findprime_lo", 32'(FindPrime), 32'd0);
      wait_done(n);
      check("seed_done_latency", 32'(n + 1), 32'(W + 1));
      check("seed_prime_out", 32'(prime_out), 32'd11);
      tick();
      check("seed_done_fall", 32'(done), 32'd0);
      check("seed_busy_fall", 32'(busy), 32'd0);
      start = 1'b0;
      tick();

      // zero seed maps to 1
      seed = 7'h00; seed_load = 1'b1;
      tick();
      seed_load = 1'b0; start = 1'b1;
      tick();
      check("zero_q_in", 32'(Q_in), 32'h01);
      start = 1'b0;
      wait_done(n);
      check("zero_prime_out", 32'(prime_out), 32'd2);
      tick();
      tick();

      // held start, then a second rising edge inside WAIT
      fp0 = fp_cnt; d0 = done_cnt;
      start = 1'b1;
      repeat (500) tick();
      check("held_findprime_cnt", 32'(fp_cnt - fp0), 32'd1);
      check("held_done_cnt", 32'(done_cnt - d0), 32'd1);
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      repeat (50) tick();
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(n);
      tick();
      check("retrig_findprime_cnt", 32'(fp_cnt - fp0), 32'd2);
      check("retrig_done_cnt", 32'(done_cnt - d0), 32'd2);
      check("retrig_busy", 32'(busy), 32'd0);

      // seed load during WAIT
      start = 1'b1;
      tick();
      q_hold = Q_in;
      start = 1'b0;
      repeat (20) tick();
      seed = 7'h33; seed_load = 1'b1;
      tick();
      seed_cyc = cyc;
      seed_load = 1'b0;
      check("wseed_q_in_hold", 32'(Q_in), 32'(q_hold));
      wait_done(n);
      check("wseed_q_in_stable", 32'(Q_in), 32'(q_hold));
      check("wseed_prime_out", 32'(prime_out), 32'(next_prime(q_hold)));
      tick();
      start = 1'b1;
      tick();
      exp_q = 7'h33;
      for (int i = 0; i < cyc - seed_cyc - 1; i++) exp_q = lfsr_step(exp_q);
      check("wseed_next_q_in", 32'(Q_in), 32'(exp_q));
      start = 1'b0;
      wait_done(n);
      tick();
      tick();

      // reset in the middle of WAIT
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (50) tick();
      #2 rst = 1'b0;
      #1;
      check("mid_rst_q_in", 32'(Q_in), 32'd0);
      check("mid_rst_findprime", 32'(FindPrime), 32'd0);
      check("mid_rst_prime_out", 32'(prime_out), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      d0 = done_cnt;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      check("post_rst_state", 32'(dut.state_q), 32'd0);
      check("post_rst_lfsr", 32'(dut.lfsr_q), 32'h01);
      tick();
      check("post_rst_lfsr_step", 32'(dut.lfsr_q), 32'h02);
      repeat (250) tick();
      check("post_rst_no_done", 32'(done_cnt - d0), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
